// File: rtl/data_sampler.sv
// Lossy receive-side sampler for a fire-and-forget valid/data crossing from a faster domain; optional capture counter under DATA_SAMPLER_CNT_EN.
// Latency: valid_i seen high at edge N -> valid_o/data_o during the cycle after edge N+SYNC_STAGES-1.
// Backpressure: none; pulses narrower than a slow_clk period may be dropped silently.
module data_sampler #(
   parameter int DATA_W      = 64,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic              slow_clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o
`ifdef DATA_SAMPLER_CNT_EN
   ,
   output logic [CNT_W-1:0]  cnt_o
`endif
);

   // Reject illegal configurations at elaboration time.
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || CNT_W < 1 || DATA_W < 1) begin : g_param_check
      $error("data_sampler: illegal parameter set");
   end

   // v_stg[0] is the capture flop; the rest are metastability stages.
   logic [SYNC_STAGES-1:0] v_stg;
   // d_stg[0] is the capture register; each shadow stage moves in lockstep
   // with its valid stage, so the word never changes while its valid is
   // in flight and never loads from an idle bus.
   logic [DATA_W-1:0]      d_stg [SYNC_STAGES];

   // Capture valid/data, then walk the valid through the chain with its data shadow.
   always_ff @(posedge slow_clk or negedge rst_n) begin
      if (!rst_n) begin
         v_stg <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            d_stg[i] <= '0;
         end
      end else begin
         v_stg <= {v_stg[SYNC_STAGES-2:0], valid_i};
         if (valid_i) begin
            d_stg[0] <= data_i;
         end
         for (int i = 1; i < SYNC_STAGES; i++) begin
            if (v_stg[i-1]) begin
               d_stg[i] <= d_stg[i-1];
            end
         end
      end
   end

   // Outputs come straight from the last stage flops; no input reaches them combinationally.
   assign valid_o = v_stg[SYNC_STAGES-1];
   assign data_o  = d_stg[SYNC_STAGES-1];

`ifdef DATA_SAMPLER_CNT_EN
   // Saturating count of delivered samples; reflects a strobe one cycle later.
   always_ff @(posedge slow_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_o <= '0;
      end else if (valid_o && (cnt_o != {CNT_W{1'b1}})) begin
         cnt_o <= cnt_o + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_data_sampler.sv
// Self-checking bench for data_sampler: scoreboard of edge-sampled words vs delivered strobes.
// Inputs change only away from slow_clk rising edges so the model's view of each sample is exact.
// Outputs are checked on slow_clk falling edges.
`timescale 1ns/1ps
module tb_data_sampler;

   localparam int DW = 64;
   localparam int SS = 2;

   logic          slow_clk = 1'b0;
   logic          fast_clk = 1'b0;
   logic          rst_n    = 1'b0;
   logic          valid_i  = 1'b0;
   logic [DW-1:0] data_i   = '0;
   logic [DW-1:0] data_o;
   logic          valid_o;
`ifdef DATA_SAMPLER_CNT_EN
   logic [15:0]   cnt_o;
   logic [1:0]    sat_cnt;
   logic [DW-1:0] sat_data;
   logic          sat_valid;
`endif

   data_sampler #(.DATA_W(DW), .SYNC_STAGES(SS), .CNT_W(16)) u_dut (
      .slow_clk (slow_clk),
      .rst_n    (rst_n),
      .data_i   (data_i),
      .valid_i  (valid_i),
      .data_o   (data_o),
      .valid_o  (valid_o)
`ifdef DATA_SAMPLER_CNT_EN
      ,
      .cnt_o    (cnt_o)
`endif
   );

`ifdef DATA_SAMPLER_CNT_EN
   data_sampler #(.DATA_W(DW), .SYNC_STAGES(SS), .CNT_W(2)) u_sat (
      .slow_clk (slow_clk),
      .rst_n    (rst_n),
      .data_i   (data_i),
      .valid_i  (valid_i),
      .data_o   (sat_data),
      .valid_o  (sat_valid),
      .cnt_o    (sat_cnt)
   );
`endif

   // Periods chosen so fast-domain changes never coincide with a slow rising edge.
   always #16.667 slow_clk = ~slow_clk;
   always #5      fast_clk = ~fast_clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [DW-1:0] d;
      int            due;
   } exp_t;

   exp_t          q[$];
   int            cyc     = 0;
   int            pushed  = 0;
   int            seen    = 0;
   int            exp_cnt = 0;
   bit            exp_v;
   logic [DW-1:0] last_d  = '0;

   // Model: every rising edge that sees valid_i=1 out of reset yields one sample.
   always @(posedge slow_clk) begin
      cyc++;
      if (rst_n && valid_i === 1'b1) begin
         q.push_back('{d: data_i, due: cyc + SS - 1});
         pushed++;
      end
   end

   // Output checker on the falling edge.
   always @(negedge slow_clk) begin
      if (!rst_n) begin
         q.delete();
         last_d  = '0;
         exp_cnt = 0;
         chk("rst_valid", 64'(valid_o), 64'd0);
         chk("rst_data", data_o, 64'd0);
`ifdef DATA_SAMPLER_CNT_EN
         chk("rst_cnt", 64'(cnt_o), 64'd0);
         chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
`endif
      end else begin
         exp_v = (q.size() > 0) && (q[0].due == cyc);
`ifdef DATA_SAMPLER_CNT_EN
         chk("cnt", 64'(cnt_o), 64'((exp_cnt > 65535) ? 65535 : exp_cnt));
         chk("sat_cnt", 64'(sat_cnt), 64'((exp_cnt > 3) ? 3 : exp_cnt));
         chk("sat_valid", 64'(sat_valid), 64'(valid_o));
         chk("sat_data", sat_data, data_o);
`endif
         if (valid_o || exp_v) begin
            chk("valid_o", 64'(valid_o), 64'(exp_v));
         end
         if (exp_v) begin
            last_d = q[0].d;
            void'(q.pop_front());
            exp_cnt++;
         end
         chk("data_o", data_o, last_d);
         if (valid_o) seen++;
      end
   end

   // Step to mid-low phase of slow_clk, well clear of both edges.
   task automatic slow_step();
      @(negedge slow_clk);
      #5;
   endtask

   task automatic pulse_slow(input logic [DW-1:0] v);
      slow_step();
      valid_i = 1'b1;
      data_i  = v;
      slow_step();
      valid_i = 1'b0;
      data_i  = 'x;
   endtask

   int s0;
   int p0;

   initial begin
      // Reset held while inputs toggle.
      for (int i = 0; i < 6; i++) begin
         slow_step();
         valid_i = 1'($urandom % 2);
         data_i  = {$urandom, $urandom};
      end
      slow_step();
      valid_i = 1'b0;
      data_i  = 'x;
      rst_n   = 1'b1;
      repeat (3) slow_step();

      // Single wide pulse.
      s0 = seen;
      pulse_slow(64'h5);
      repeat (6) slow_step();
      chk("wide_count", 64'(seen - s0), 64'd1);
      chk("wide_data", data_o, 64'h5);

      // Narrow pulse between rising edges.
      s0 = seen;
      slow_step();
      valid_i = 1'b1;
      data_i  = 64'h77;
      #10;
      valid_i = 1'b0;
      data_i  = 'x;
      repeat (6) slow_step();
      chk("narrow_count", 64'(seen - s0), 64'd0);
      chk("narrow_data", data_o, 64'h5);

      // Valid held for three edges.
      s0 = seen;
      slow_step();
      valid_i = 1'b1;
      data_i  = 64'hA;
      slow_step();
      data_i  = 64'hB;
      slow_step();
      data_i  = 64'hC;
      slow_step();
      valid_i = 1'b0;
      data_i  = 'x;
      repeat (6) slow_step();
      chk("held_count", 64'(seen - s0), 64'd3);
      chk("held_data", data_o, 64'hC);

      // Burst of 20 one-fast-cycle pulses with random gaps.
      s0 = seen;
      p0 = pushed;
      slow_step();
      for (int v = 1; v <= 20; v++) begin
         @(posedge fast_clk);
         valid_i = 1'b1;
         data_i  = 64'(v);
         @(posedge fast_clk);
         valid_i = 1'b0;
         data_i  = 'x;
         repeat ($urandom_range(5, 1) - 1) @(posedge fast_clk);
      end
      repeat (8) slow_step();
      chk("burst_count", 64'(seen - s0), 64'(pushed - p0));
      chk("burst_le20", 64'((seen - s0) <= 20), 64'd1);

      // Reset one cycle after a capture discards the sample.
      s0 = seen;
      pulse_slow(64'hDEAD);
      rst_n = 1'b0;
      repeat (2) slow_step();
      rst_n = 1'b1;
      repeat (5) slow_step();
      chk("midrst_count", 64'(seen - s0), 64'd0);
      chk("midrst_data", data_o, 64'd0);

      // Fresh captures after reset.
      s0 = seen;
      pulse_slow(64'h11);
      pulse_slow(64'h22);
      pulse_slow(64'h33);
      repeat (5) slow_step();
      chk("post_rst_count", 64'(seen - s0), 64'd3);
      chk("post_rst_data", data_o, 64'h33);
`ifdef DATA_SAMPLER_CNT_EN
      chk("cnt_after3", 64'(cnt_o), 64'd3);
`endif
      pulse_slow(64'h44);
      pulse_slow(64'h55);
      repeat (5) slow_step();
      chk("post_rst_count5", 64'(seen - s0), 64'd5);
`ifdef DATA_SAMPLER_CNT_EN
      chk("cnt_after5", 64'(cnt_o), 64'd5);
      chk("sat_after5", 64'(sat_cnt), 64'd3);
`endif
      chk("queue_drained", 64'(q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
